// File: rtl/timer_bus.sv
// timer_bus: memory-mapped 32-bit timer/compare peripheral on the data bus.
//
// A prescaler divides clk into ticks. Each tick advances COUNT and compares
// it against COMPARE. A hit sets STATUS.match, which drives timer_int when
// CTRL.ie is set. With CTRL.reload set, COUNT restarts at 0 after a hit,
// which gives a periodic tick.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   bus_sel    slave select; request = bus_sel & (bus_we | bus_re)
//   bus_we     write strobe (wins over bus_re when both are set)
//   bus_re     read strobe
//   bus_addr   word offset inside the segment
//   bus_wdata  write data
//   bus_rdata  registered read data, valid while bus_ack=1, else 0
//   bus_ack    one-cycle acknowledge, the cycle after the request
//   timer_int  level interrupt = STATUS.match & CTRL.ie
//
// Register map (word offsets):
//   0 CTRL      [0] en, [1] ie, [2] reload
//   1 PRESCALE  [PRESCALE_W-1:0] divisor; a tick every PRESCALE+1 cycles
//   2 COUNT     32-bit read/write
//   3 COMPARE   32-bit read/write
//   4 STATUS    [0] match, write 1 to clear
//   5-7         read 0, writes ignored, still acked
module timer_bus #(
  parameter int          PRESCALE_W    = 16,
  parameter int          ADDR_W        = 3,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic              timer_int
);

  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_COUNT    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_COMPARE  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(4);

  logic                  en;
  logic                  ie;
  logic                  reload;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  match;

  logic                  req;
  logic                  wr;
  logic                  tick;
  logic                  hit;
  logic [31:0]           rd_val;

  assign req  = bus_sel & (bus_we | bus_re);
  assign wr   = req & bus_we;
  assign tick = en && (pcnt == prescale);
  // Compared against the current COMPARE, so a same-cycle COMPARE write
  // only affects later ticks.
  assign hit  = tick && (count == compare);

  assign timer_int = match & ie;

  // Read mux samples the registers before any write in this cycle lands,
  // so a combined write/read returns the pre-write value.
  always_comb begin
    rd_val = '0;
    case (bus_addr)
      A_CTRL:     rd_val[2:0] = {reload, ie, en};
      A_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale;
      A_COUNT:    rd_val = count;
      A_COMPARE:  rd_val = compare;
      A_STATUS:   rd_val[0] = match;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      reload    <= 1'b0;
      prescale  <= '0;
      pcnt      <= '0;
      count     <= '0;
      compare   <= RESET_COMPARE;
      match     <= 1'b0;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      // Bus response stage: ack and data one cycle after the request.
      bus_ack   <= req;
      bus_rdata <= req ? rd_val : 32'd0;

      if (wr && bus_addr == A_CTRL) begin
        en     <= bus_wdata[0];
        ie     <= bus_wdata[1];
        reload <= bus_wdata[2];
      end

      if (wr && bus_addr == A_PRESCALE) begin
        prescale <= bus_wdata[PRESCALE_W-1:0];
      end

      if (wr && bus_addr == A_COMPARE) begin
        compare <= bus_wdata;
      end

      // Prescaler: a PRESCALE write restarts the divide so the new period
      // begins cleanly.
      if (wr && bus_addr == A_PRESCALE) begin
        pcnt <= '0;
      end else if (!en || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end

      // Counter: a bus write overrides the tick in the same cycle.
      if (wr && bus_addr == A_COUNT) begin
        count <= bus_wdata;
      end else if (tick) begin
        if (hit && reload) count <= 32'd0;
        else               count <= count + 32'd1;
      end

      // Match flag: a hit beats a simultaneous write-1-to-clear.
      if (hit) begin
        match <= 1'b1;
      end else if (wr && bus_addr == A_STATUS && bus_wdata[0]) begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_bus.sv
module tb_timer_bus;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_COUNT    = 3'd2;
  localparam logic [2:0] A_COMPARE  = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;
  localparam logic [2:0] A_UNUSED   = 3'd5;

  logic        clk;
  logic        rst;
  logic        bus_sel;
  logic        bus_we;
  logic        bus_re;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        timer_int;

  int total = 0;
  int bad   = 0;

  timer_bus #(
    .PRESCALE_W(16),
    .ADDR_W(3),
    .RESET_COMPARE(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_sel(bus_sel),
    .bus_we(bus_we),
    .bus_re(bus_re),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .timer_int(timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // One bus request in the cycle after the next falling edge; returns just
  // after the rising edge that ends the request cycle, when ack/rdata for
  // that request are on the outputs.
  task automatic bus_xfer(input logic [2:0] a, input logic [31:0] v,
                          input logic we, input logic re,
                          output logic [31:0] d, output logic k);
    @(negedge clk);
    bus_sel   = 1'b1;
    bus_we    = we;
    bus_re    = re;
    bus_addr  = a;
    bus_wdata = v;
    @(posedge clk);
    #1;
    bus_sel   = 1'b0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    bus_wdata = '0;
    d = bus_rdata;
    k = bus_ack;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    logic [31:0] d;
    logic k;
    bus_xfer(a, v, 1'b1, 1'b0, d, k);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic k);
    bus_xfer(a, 32'd0, 1'b0, 1'b1, d, k);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic k;
    logic [31:0] exp_val [5];
    logic [2:0]  addrs   [5];
    rst = 1'b0;
    bus_sel = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus_ack, bus_rdata, timer_int} !== 34'd0) begin
      bad++;
      $display("FAIL reset_outputs got ack=%b rdata=%h int=%b want all 0", bus_ack, bus_rdata, timer_int);
    end
    @(negedge clk);
    rst = 1'b1;
    addrs   = '{A_CTRL, A_PRESCALE, A_COUNT, A_COMPARE, A_STATUS};
    exp_val = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 5; i++) begin
      bus_read(addrs[i], d, k);
      total++;
      if (k !== 1'b1 || d !== exp_val[i]) begin
        bad++;
        $display("FAIL reset_read[%0d] got ack=%b data=%h want ack=1 data=%h", i, k, d, exp_val[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'd0 || timer_int !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got ack=%b rdata=%h int=%b want 0 0 0", bus_ack, bus_rdata, timer_int);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic k;
    bus_write(A_COMPARE, 32'h1234_5678);
    total++;
    if (bus_ack !== 1'b1) begin
      bad++;
      $display("FAIL b2b_write_ack got %b want 1", bus_ack);
    end
    bus_read(A_COMPARE, d, k);
    total++;
    if (k !== 1'b1 || d !== 32'h1234_5678) begin
      bad++;
      $display("FAIL b2b_read got ack=%b data=%h want ack=1 data=12345678", k, d);
    end
    // we and re together: write wins, data is the old value
    bus_xfer(A_COMPARE, 32'hAAAA_5555, 1'b1, 1'b1, d, k);
    total++;
    if (k !== 1'b1 || d !== 32'h1234_5678) begin
      bad++;
      $display("FAIL rw_both got ack=%b data=%h want ack=1 data=12345678", k, d);
    end
    bus_read(A_COMPARE, d, k);
    total++;
    if (d !== 32'hAAAA_5555) begin
      bad++;
      $display("FAIL rw_both_after got %h want aaaa5555", d);
    end
    bus_write(A_UNUSED, 32'hDEAD_BEEF);
    total++;
    if (bus_ack !== 1'b1) begin
      bad++;
      $display("FAIL unused_write_ack got %b want 1", bus_ack);
    end
    bus_read(A_UNUSED, d, k);
    total++;
    if (k !== 1'b1 || d !== 32'd0) begin
      bad++;
      $display("FAIL unused_read got ack=%b data=%h want ack=1 data=0", k, d);
    end
    bus_write(A_CTRL, 32'hFFFF_FFF8);
    bus_read(A_CTRL, d, k);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL ctrl_mask got %h want 0", d);
    end
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    logic k;
    bus_write(A_PRESCALE, 32'd3);
    bus_write(A_COMPARE, 32'd4);
    bus_write(A_CTRL, 32'd7);
    // read in cycle c (c=1 is the first cycle with en=1) returns COUNT
    // during that cycle; timer_int afterwards reflects cycle c+1
    for (int c = 1; c <= 21; c++) begin
      bus_read(A_COUNT, d, k);
      total++;
      if (d !== ((c <= 20) ? 32'((c - 1) / 4) : 32'd0)) begin
        bad++;
        $display("FAIL periodic_count[c=%0d] got %h want %h", c, d,
                 (c <= 20) ? 32'((c - 1) / 4) : 32'd0);
      end
      total++;
      if (timer_int !== (c >= 20)) begin
        bad++;
        $display("FAIL periodic_int[c=%0d] got %b want %b", c, timer_int, (c >= 20));
      end
    end
    bus_write(A_STATUS, 32'd1);   // cycle 22
    total++;
    if (timer_int !== 1'b0) begin
      bad++;
      $display("FAIL periodic_w1c got int=%b want 0", timer_int);
    end
    for (int c = 23; c <= 40; c++) begin
      @(posedge clk); #1;
      total++;
      if (timer_int !== (c >= 40)) begin
        bad++;
        $display("FAIL periodic_rerise[c=%0d] got %b want %b", c, timer_int, (c >= 40));
      end
    end
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    logic k;
    logic [31:0] want;
    bus_write(A_COUNT, 32'hFFFF_FFFE);
    bus_write(A_PRESCALE, 32'd0);
    bus_write(A_COMPARE, 32'd5);
    bus_write(A_CTRL, 32'd3);
    for (int c = 1; c <= 9; c++) begin
      want = 32'hFFFF_FFFE + 32'(c - 1);
      bus_read(A_COUNT, d, k);
      total++;
      if (d !== want) begin
        bad++;
        $display("FAIL wrap_count[c=%0d] got %h want %h", c, d, want);
      end
      total++;
      if (timer_int !== (c >= 8)) begin
        bad++;
        $display("FAIL wrap_int[c=%0d] got %b want %b", c, timer_int, (c >= 8));
      end
    end
  endtask

  task automatic test_collisions;
    logic [31:0] d;
    logic k;
    // still ticking every cycle from the wrap scenario
    bus_write(A_COUNT, 32'd100);
    bus_read(A_COUNT, d, k);
    total++;
    if (d !== 32'd100) begin
      bad++;
      $display("FAIL count_write_vs_tick got %0d want 100", d);
    end
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, d, k);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL status_cleared got %h want 0", d);
    end
    bus_write(A_COUNT, 32'd0);
    bus_write(A_COMPARE, 32'd2);
    bus_write(A_CTRL, 32'd1);     // en only
    bus_read(A_COUNT, d, k);      // cycle 1
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL w1c_setup_c1 got %h want 0", d);
    end
    bus_read(A_COUNT, d, k);      // cycle 2
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL w1c_setup_c2 got %h want 1", d);
    end
    bus_write(A_STATUS, 32'd1);   // cycle 3: COUNT==COMPARE tick
    bus_write(A_CTRL, 32'd0);     // cycle 4: still ticks once more
    bus_read(A_STATUS, d, k);
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL set_vs_w1c got %h want 1", d);
    end
    bus_read(A_COUNT, d, k);
    total++;
    if (d !== 32'd4) begin
      bad++;
      $display("FAIL count_after_stop got %h want 4", d);
    end
  endtask

  task automatic test_masking;
    logic [31:0] d;
    logic k;
    bus_write(A_CTRL, 32'd3);
    total++;
    if (timer_int !== 1'b1) begin
      bad++;
      $display("FAIL mask_ie_on got %b want 1", timer_int);
    end
    bus_write(A_CTRL, 32'd1);
    total++;
    if (timer_int !== 1'b0) begin
      bad++;
      $display("FAIL mask_ie_off got %b want 0", timer_int);
    end
    bus_read(A_STATUS, d, k);
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL mask_status got %h want 1", d);
    end
    bus_write(A_CTRL, 32'd3);
    total++;
    if (timer_int !== 1'b1) begin
      bad++;
      $display("FAIL mask_ie_back got %b want 1", timer_int);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    logic k;
    // counting with ie=1 and match=1; issue a read, then reset between edges
    @(negedge clk);
    bus_sel = 1'b1; bus_re = 1'b1; bus_addr = A_COMPARE;
    @(posedge clk); #2;
    total++;
    if (bus_ack !== 1'b1 || bus_rdata !== 32'd2 || timer_int !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got ack=%b rdata=%h int=%b want 1 00000002 1", bus_ack, bus_rdata, timer_int);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'd0 || timer_int !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got ack=%b rdata=%h int=%b want 0 0 0", bus_ack, bus_rdata, timer_int);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus_sel = 1'b0; bus_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus_ack !== 1'b0) begin
        bad++;
        $display("FAIL no_ack_after_reset[%0d] got %b want 0", i, bus_ack);
      end
    end
    bus_read(A_COMPARE, d, k);
    total++;
    if (k !== 1'b1 || d !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL compare_after_reset got ack=%b data=%h want ack=1 data=ffffffff", k, d);
    end
    bus_read(A_COUNT, d, k);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL count_after_reset got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_periodic();
    test_wrap();
    test_collisions();
    test_masking();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
